// File: rtl/memory_interface.sv
// Memory interface between the MAR/MDR datapath and a single-port RAM.
// Handles one read or write at a time, waits for ram_ready with a bounded
// wait counter and reports success (done) or abandonment (timeout_err).
module memory_interface #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [31:0]       mar_addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       mdr_data_in,
  output logic              mdr_read,
  output logic              mdr_enable,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_LOAD = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        wdata_r;
  logic [31:0]        rdata_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic               timeout_err_r;

  logic               accept_rd_s;
  logic               accept_wr_s;
  logic               capture_s;
  logic               expire_s;
  logic               count_s;
  logic               last_wait_s;
  logic               unused_addr_s;

  // Only the low ADDR_W bits of the MAR address the RAM.
  assign unused_addr_s = ^mar_addr[31:ADDR_W];

  // The access is abandoned when the wait that just ended was the last allowed one.
  assign last_wait_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a read wins over a simultaneous write, and ready beats timeout.
  always_comb begin
    state_s     = state_r;
    accept_rd_s = 1'b0;
    accept_wr_s = 1'b0;
    capture_s   = 1'b0;
    expire_s    = 1'b0;
    count_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_req) begin
          accept_rd_s = 1'b1;
          state_s     = RD_WAIT;
        end else if (wr_req) begin
          accept_wr_s = 1'b1;
          state_s     = WR_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (ram_ready) begin
          capture_s = 1'b1;
          state_s   = RD_LOAD;
        end else if (last_wait_s) begin
          count_s  = 1'b1;
          expire_s = 1'b1;
          state_s  = IDLE;
        end else begin
          count_s = 1'b1;
          state_s = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (ram_ready) begin
          state_s = WR_DONE;
        end else if (last_wait_s) begin
          count_s  = 1'b1;
          expire_s = 1'b1;
          state_s  = IDLE;
        end else begin
          count_s = 1'b1;
          state_s = WR_WAIT;
        end
      end
      RD_LOAD: state_s = IDLE;
      WR_DONE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Moore outputs decoded purely from the current state.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    mdr_read   = 1'b0;
    mdr_enable = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      RD_WAIT: begin
        busy   = 1'b1;
        ram_re = 1'b1;
      end
      RD_LOAD: begin
        busy       = 1'b1;
        done       = 1'b1;
        mdr_read   = 1'b1;
        mdr_enable = 1'b1;
      end
      WR_WAIT: begin
        busy   = 1'b1;
        ram_we = 1'b1;
      end
      WR_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Address register, loaded on any accepted request and held for the access.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      addr_r <= '0;
    end else if (accept_rd_s || accept_wr_s) begin
      addr_r <= mar_addr[ADDR_W-1:0];
    end else begin
      addr_r <= addr_r;
    end
  end

  // Write-data register, loaded only when a write is actually accepted.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wdata_r <= 32'd0;
    end else if (accept_wr_s) begin
      wdata_r <= wr_data;
    end else begin
      wdata_r <= wdata_r;
    end
  end

  // Read-data register, keeps the last successfully read word.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rdata_r <= 32'd0;
    end else if (capture_s) begin
      rdata_r <= ram_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Wait counter, cleared on accept and advanced on each un-acknowledged wait cycle.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt_r <= '0;
    end else if (accept_rd_s || accept_wr_s) begin
      wait_cnt_r <= '0;
    end else if (count_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky timeout flag, cleared only by the next accepted request or reset.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      timeout_err_r <= 1'b0;
    end else if (accept_rd_s || accept_wr_s) begin
      timeout_err_r <= 1'b0;
    end else if (expire_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign ram_addr    = addr_r;
  assign ram_wdata   = wdata_r;
  assign mdr_data_in = rdata_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_memory_interface.sv
// Self-checking bench for memory_interface: the bench plays the RAM, keeps a
// transaction-level model of what every output must show each cycle, and
// compares it on the falling clock edge.
module tb_memory_interface;

  localparam int AW = 9;
  localparam int T  = 15;

  logic          clock;
  logic          clear;
  logic          rd_req;
  logic          wr_req;
  logic [31:0]   mar_addr;
  logic [31:0]   wr_data;
  logic [31:0]   mdr_data_in;
  logic          mdr_read;
  logic          mdr_enable;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_re;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic          ram_ready;

  memory_interface #(.ADDR_W(AW), .TIMEOUT(T)) dut (
    .clock       (clock),
    .clear       (clear),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .mar_addr    (mar_addr),
    .wr_data     (wr_data),
    .mdr_data_in (mdr_data_in),
    .mdr_read    (mdr_read),
    .mdr_enable  (mdr_enable),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_re      (ram_re),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .ram_ready   (ram_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ctrl = {busy, done, ram_re, ram_we, mdr_read, mdr_enable, timeout_err}
  typedef struct packed {
    logic [6:0]    ctrl;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   mdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_mdata;
  logic          m_terr;
  int            total;
  int            bad;
  int            done_cnt;
  int            re_cnt;
  int            we_cnt;
  int            me_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic dn, input logic re,
                              input logic we, input logic mr, input logic me);
    exp_t e;
    e.ctrl  = {b, dn, re, we, mr, me, m_terr};
    e.addr  = m_addr;
    e.wdata = m_wdata;
    e.mdata = m_mdata;
    return e;
  endfunction

  // Per-cycle comparison of the DUT against the model's expected trace.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctrl", {25'd0, busy, done, ram_re, ram_we, mdr_read, mdr_enable, timeout_err},
          {25'd0, e.ctrl});
      chk("ram_addr", {23'd0, ram_addr}, {23'd0, e.addr});
      chk("ram_wdata", ram_wdata, e.wdata);
      chk("mdr_data_in", mdr_data_in, e.mdata);
    end
  end

  // Event counters used by the directed literal checks.
  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (ram_re === 1'b1) re_cnt++;
    if (ram_we === 1'b1) we_cnt++;
    if (mdr_enable === 1'b1) me_cnt++;
  end

  task automatic chk_zero(input string name);
    chk({name, "_ctrl"}, {25'd0, busy, done, ram_re, ram_we, mdr_read, mdr_enable, timeout_err}, 32'd0);
    chk({name, "_addr"}, {23'd0, ram_addr}, 32'd0);
    chk({name, "_wdata"}, ram_wdata, 32'd0);
    chk({name, "_mdata"}, mdr_data_in, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b0; wr_req = 1'b0;
      mar_addr = $urandom; wr_data = $urandom;
      ram_ready = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clock); #1;
    end
  endtask

  // kind: 0 read, 1 write, 2 read+write together; k: wait cycle in which
  // ram_ready is raised (values outside 1..T mean never, so the access times out).
  task automatic access(input int kind, input logic [31:0] a, input logic [31:0] d, input int k);
    logic          is_rd;
    logic          ok;
    int            n;
    logic [AW-1:0] wa;
    is_rd = (kind != 1);
    rd_req = is_rd; wr_req = (kind != 0);
    mar_addr = a; wr_data = d;
    ram_ready = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock); #1;
    wa = a[AW-1:0];
    m_addr = wa;
    if (!is_rd) m_wdata = d;
    m_terr = 1'b0;
    ok = (k >= 1 && k <= T);
    n = ok ? k : T;
    for (int j = 1; j <= n; j++) begin
      rd_req = 1'($urandom_range(0, 1)); wr_req = 1'($urandom_range(0, 1));
      mar_addr = $urandom; wr_data = $urandom;
      ram_ready = (j == k);
      ram_rdata = (j == k && is_rd) ? mem[wa] : $urandom;
      exp_q.push_back(mk(1'b1, 1'b0, is_rd, !is_rd, 1'b0, 1'b0));
      @(posedge clock); #1;
    end
    if (ok) begin
      if (is_rd) m_mdata = mem[wa];
      else mem[wa] = d;
      rd_req = 1'($urandom_range(0, 1)); wr_req = 1'($urandom_range(0, 1));
      ram_ready = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, is_rd, is_rd));
      @(posedge clock); #1;
    end else begin
      m_terr = 1'b1;
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  // Starts a read, then pulls clear low between edges while in RD_WAIT.
  // Returns with clear released and a clock edge still ahead.
  task automatic mid_reset(input logic [31:0] a);
    rd_req = 1'b1; wr_req = 1'b0; mar_addr = a; ram_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock); #1;
    m_addr = a[AW-1:0]; m_terr = 1'b0;
    rd_req = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    #6;
    clear = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge clock); #1;
    chk_zero("rst_held");
    m_addr = '0; m_wdata = 32'd0; m_mdata = 32'd0; m_terr = 1'b0;
    #3;
    clear = 1'b1;
  endtask

  initial begin
    int d0, r0, w0, e0;
    total = 0; bad = 0;
    done_cnt = 0; re_cnt = 0; we_cnt = 0; me_cnt = 0;
    m_addr = '0; m_wdata = 32'd0; m_mdata = 32'd0; m_terr = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    clear = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    mar_addr = 32'd0; wr_data = 32'd0; ram_rdata = 32'd0; ram_ready = 1'b0;
    #2;
    chk_zero("reset");
    @(posedge clock); #4;
    clear = 1'b1;

    // Read with ready in the first wait cycle.
    mem[9'h105] = 32'hDEADBEEF;
    d0 = done_cnt; r0 = re_cnt; e0 = me_cnt;
    access(0, 32'h0000_0105, 32'd0, 1);
    chk("rd_data", mdr_data_in, 32'hDEADBEEF);
    chk("rd_addr", {23'd0, ram_addr}, 32'h0000_0105);
    chk("rd_re_cycles", re_cnt - r0, 1);
    chk("rd_done", done_cnt - d0, 1);
    chk("rd_mdr_en", me_cnt - e0, 1);

    // Write with ready after four wait cycles.
    d0 = done_cnt; w0 = we_cnt; e0 = me_cnt;
    access(1, 32'h0000_0003, 32'h12345678, 4);
    chk("wr_data", ram_wdata, 32'h12345678);
    chk("wr_we_cycles", we_cnt - w0, 4);
    chk("wr_done", done_cnt - d0, 1);
    chk("wr_mdr_en", me_cnt - e0, 0);

    // Simultaneous requests: read only.
    w0 = we_cnt; r0 = re_cnt;
    access(2, 32'hFFFF_FF05, 32'hCAFEF00D, 2);
    chk("both_no_we", we_cnt - w0, 0);
    chk("both_re", re_cnt - r0, 2);
    chk("both_wdata", ram_wdata, 32'h12345678);

    // Timeout with ready held low.
    d0 = done_cnt; r0 = re_cnt; e0 = me_cnt;
    access(0, 32'h0000_0007, 32'd0, 0);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_mdata", mdr_data_in, 32'hDEADBEEF);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_re_cycles", re_cnt - r0, T);
    chk("to_no_load", me_cnt - e0, 0);
    idle(2);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    access(0, 32'h0000_0105, 32'd0, 1);
    chk("to_cleared", {31'd0, timeout_err}, 32'd0);

    // Ready on the last allowed wait cycle is a success.
    access(1, 32'h0000_0011, 32'd0, 0);
    d0 = done_cnt;
    access(1, 32'h0000_0011, 32'hA5A5_5A5A, T);
    chk("edge_done", done_cnt - d0, 1);
    chk("edge_err", {31'd0, timeout_err}, 32'd0);

    // Reset in the middle of a read, then an immediate request.
    d0 = done_cnt;
    mid_reset(32'h0000_0042);
    chk("rst_no_done", done_cnt - d0, 0);
    access(0, 32'h0000_0105, 32'd0, 3);
    chk("rst_first_req", mdr_data_in, 32'hDEADBEEF);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int kind, k;
      kind = $urandom_range(0, 2);
      k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T);
      access(kind, $urandom, $urandom, k);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 Parameter ADDR_W SHALL default to 9 and set the RAM word-address width (512 words).
REQ-002 Parameter TIMEOUT SHALL default to 15 and set the maximum wait cycles for ram_ready.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge system clock shared with the datapath.
REQ-005 clear  input  1  asynchronous, active-low reset.
REQ-006 rd_req  input  1  read request from the control unit, sampled only in IDLE.
REQ-007 wr_req  input  1  write request from the control unit, sampled only in IDLE.
REQ-008 mar_addr  input  32  MAR register output; only bits [ADDR_W-1:0] are used.
REQ-009 wr_data  input  32  MDR register output, the data to write.
REQ-010 mdr_data_in  output  32  read data presented to the MDR memory-side input.
REQ-011 mdr_read  output  1  MDR source select (1 = memory side).
REQ-012 mdr_enable  output  1  MDR load strobe.
REQ-013 busy  output  1  high while an access is in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 timeout_err  output  1  sticky flag for an access that was abandoned.
REQ-016 ram_addr  output  ADDR_W  RAM word address.
REQ-017 ram_wdata  output  32  RAM write data.
REQ-018 ram_re  output  1  RAM read strobe.
REQ-019 ram_we  output  1  RAM write strobe.
REQ-020 ram_rdata  input  32  RAM read data, valid when ram_ready=1.
REQ-021 ram_ready  input  1  RAM completion acknowledge.

Function
REQ-022 The FSM SHALL have the states IDLE, RD_WAIT, RD_LOAD, WR_WAIT and WR_DONE.
REQ-023 In IDLE with rd_req=1, the block SHALL latch mar_addr[ADDR_W-1:0] into the address register, clear wait_cnt and timeout_err, and move to RD_WAIT.
REQ-024 In IDLE with wr_req=1 and rd_req=0, the block SHALL latch the address and wr_data, clear wait_cnt and timeout_err, and move to WR_WAIT.
REQ-025 If rd_req and wr_req are both 1 in the same cycle, the read SHALL win and the write SHALL be dropped, not queued.
REQ-026 Requests arriving in any state other than IDLE SHALL be ignored.
REQ-027 ram_addr SHALL come from the address register and SHALL stay stable for the whole access.
REQ-028 ram_wdata SHALL come from the write-data register.
REQ-029 ram_re SHALL be 1 exactly in RD_WAIT; ram_we SHALL be 1 exactly in WR_WAIT; ram_re and ram_we SHALL never both be 1.
REQ-030 In RD_WAIT with ram_ready=1, the block SHALL capture ram_rdata into the read-data register and move to RD_LOAD.
REQ-031 RD_LOAD SHALL assert mdr_read=1, mdr_enable=1 and done=1 for exactly one cycle, then return to IDLE.
REQ-032 In WR_WAIT with ram_ready=1, the block SHALL move to WR_DONE; WR_DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-033 Latency: a request accepted at edge 0 with ram_ready first high in wait cycle k (k>=1) SHALL produce done in cycle k+1; the minimum is 2 cycles from request to done.
REQ-034 wait_cnt SHALL increment in each RD_WAIT/WR_WAIT cycle where ram_ready=0.
REQ-035 When wait_cnt reaches TIMEOUT, the FSM SHALL return to IDLE with timeout_err=1, no done, no MDR load, and no change to mdr_data_in.
REQ-036 timeout_err SHALL stay 1 until the next accepted request or reset.
REQ-037 ram_ready=1 in the same cycle that wait_cnt reaches TIMEOUT SHALL count as success, not timeout.
REQ-038 ram_ready while in IDLE, RD_LOAD or WR_DONE SHALL be ignored.
REQ-039 busy SHALL be 1 whenever state != IDLE.
REQ-040 mdr_data_in SHALL hold the last successfully read word between accesses.
REQ-041 All outputs except ram_addr, ram_wdata and mdr_data_in SHALL be decoded from the state and SHALL be glitch-free registered or Moore outputs.

Reset
REQ-042 clear=0 SHALL, at any time and without waiting for a clock edge, force the state to IDLE and set wait_cnt, all registers and all outputs to 0.
REQ-043 A reset during an access SHALL abort it with no done and no timeout_err.
REQ-044 After clear is released, the first rising edge SHALL already accept a pending request.

Verification
REQ-045 Read, ready after 1 wait cycle: addr=0x0000_0105, RAM[0x105]=0xDEADBEEF -> ram_addr=0x105, ram_re=1 for 1 cycle, then mdr_data_in=0xDEADBEEF with mdr_enable, mdr_read and done all high for 1 cycle.
REQ-046 Write, ready after 4 cycles: wr_data=0x12345678, addr=0x3 -> ram_we=1 for 4 cycles with ram_wdata=0x12345678, then done for 1 cycle, with mdr_enable=0 throughout.
REQ-047 Simultaneous rd_req and wr_req -> read only, ram_we never asserts; a wr_req while busy is ignored.
REQ-048 ram_ready held 0 -> after 15 wait cycles the block returns to IDLE, timeout_err=1, no done, mdr_data_in unchanged; the next rd_req clears timeout_err.
REQ-049 ram_ready=1 exactly on wait cycle 15 -> success (done asserted, timeout_err=0).
REQ-050 clear driven low mid-RD_WAIT, between clock edges -> all outputs 0 immediately, no done afterwards.
